zion_dat_read_pipe: RTL and testbench
=====================================

# zion_dat_read_pipe

Pipelined, handshaked successor to the combinational data-read mux. Each accepted request extracts one element from a wide input word: the element width is chosen per request from a parameter list, the lane is chosen by address, and the element is zero- or sign-extended. The block adds valid/ready flow control, a two-stage pipeline with full backpressure, error detection, a saturating error counter and a synchronous flush. It sits between register/memory read data and consumers that need narrow typed fields.

## Interface
- WIDTH_DATA_IN, 32: width of the input word; multiple of 8.
- WIDTH_DATA_OUT, 32: width of the output; at least every entry of MULTI_DATA_WIDTH.
- NUM_TYPE, 2: number of selectable element widths.
- MULTI_DATA_WIDTH, {16,8}: element width per type. Each entry is a power of two, at least 8 and at most WIDTH_DATA_IN.
- ADDR_TYPE, 0: address mode. 0 = iAddr is a lane index in element units. 1 = iAddr is a byte address; low bits must be element-aligned.
- WIDTH_ADDR, $clog2(WIDTH_DATA_IN/8): address width; derived, not overridden.
- WIDTH_ERRCNT, 8: error counter width.

Ports:
- iClk  in  1  the single clock.
- iRst_n  in  1  asynchronous, active-low reset.
- iClr  in  1  synchronous flush of the pipeline and the error counter.
- iVld  in  1  request valid.
- oRdy  out  1  request ready.
- iEn  in  NUM_TYPE  one-hot type select.
- iAddr  in  WIDTH_ADDR  lane/byte address.
- iSigned  in  1  1 = sign-extend, 0 = zero-extend.
- iDat  in  WIDTH_DATA_IN  source word.
- oVld  out  1  result valid.
- iRdy  in  1  downstream ready.
- oDat  out  WIDTH_DATA_OUT  extracted and extended element.
- oErr  out  1  result is an error response; qualified by oVld.
- oErrCnt  out  WIDTH_ERRCNT  saturating count of error responses delivered.

## Operation
- Handshake: a request is accepted on a cycle where iVld && oRdy. A result is delivered on a cycle where oVld && iRdy. Request fields are sampled only at acceptance.
- Stage 1 (S1) registers the request and computes:
  - type index t
  - element width W = MULTI_DATA_WIDTH[t]
  - lane L: iAddr in mode 0; iAddr*8/W in mode 1
  - the W-bit raw element iDat[L*W +: W]
- Stage 2 (S2) extends the raw element to WIDTH_DATA_OUT: zero-extend when iSigned=0, replicate bit W-1 when iSigned=1. The result is registered to oDat/oErr.
- Error conditions, detected in S1:
  - iEn is not one-hot (zero bits or more than one bit set)
  - lane L ≥ WIDTH_DATA_IN/W
  - mode 1 with a byte address not aligned to W/8
- On error: oDat=0 and oErr=1.
- When W equals WIDTH_DATA_IN, the address is ignored; the lane is 0 and no lane error is raised.
- oErrCnt increments when an error result is delivered (oVld && iRdy && oErr) and saturates at all-ones.
- iClr:
  - clears both stage valids and oErrCnt in the cycle it is sampled
  - forces oRdy=0 in that cycle, so no request is accepted
  - has priority over every other update

## Timing
- Reset values: oVld=0, oDat=0, oErr=0, oErrCnt=0. oRdy=1 from the first cycle after reset release.
- Latency: the result appears on oVld exactly 2 cycles after acceptance when unstalled.
- Throughput: 1 request/cycle while iRdy=1.
- Stage advance rules:
  - S2 loads when it is empty or delivering.
  - S1 advances when S2 loads.
  - oRdy = !iClr && (!S1 valid || S2 loads). oRdy is combinational from iRdy; this path is intended.
- Stall:
  - While oVld && !iRdy, oDat and oErr are held stable.
  - At most 2 requests are in flight. With both stages full and iRdy=0, oRdy=0.
- Simultaneous accept and deliver in one cycle: both occur, with no bubble.
- Reset asserted mid-operation: all in-flight requests are dropped immediately (asynchronous). No result is delivered after release.
- Error counter saturation: at all-ones, further errors leave oErrCnt unchanged.

## Test plan
- Defaults with ADDR_TYPE=1; iDat=32'hA5B6_C7D8, iEn=2'b10 (8-bit), iAddr=1, iSigned=1 -> 2 cycles later oVld=1, oDat=32'hFFFF_FFC7, oErr=0.
- Same iDat, iEn=2'b01 (16-bit), iAddr=2, iSigned=0 -> oDat=32'h0000_A5B6. Then iAddr=1 -> oErr=1, oDat=0, oErrCnt=1.
- iEn=2'b11, then iEn=2'b00 -> two error results; oErrCnt=2 after both are delivered.
- Back-to-back requests for 10 cycles with iRdy toggling 1,0,0,1,…:
  - results are in order with no loss or duplication
  - oDat is stable during stalls
  - oRdy=0 whenever both stages are full and iRdy=0
- iClr pulsed with 2 requests in flight and oErrCnt=3 -> next cycle oVld=0 and oErrCnt=0. Neither flushed request is ever delivered.
- iRst_n asserted asynchronously mid-stream -> outputs go to reset values without a clock edge. With WIDTH_ERRCNT=2, 5 errors delivered -> oErrCnt holds at 3.

Source files
------------

// File: rtl/zion_dat_read_pipe.sv
// -----------------------------------------------------------------------------
// zion_dat_read_pipe
//
// Two-stage, valid/ready pipelined element extractor. Each accepted request
// picks one element out of a wide source word: the element width comes from
// the one-hot type select, the lane from the address (lane index or byte
// address depending on ADDR_TYPE), and the element is zero- or sign-extended
// to the output width. Malformed requests produce an error response
// (oDat=0, oErr=1) and are counted in a saturating error counter.
//
// Ports:
//   iClk      clock
//   iRst_n    asynchronous active-low reset
//   iClr      synchronous flush of both stages and the error counter
//   iVld/oRdy request handshake; iEn, iAddr, iSigned, iDat sampled on accept
//   oVld/iRdy result handshake; oDat, oErr qualified by oVld
//   oErrCnt   saturating count of delivered error responses
// -----------------------------------------------------------------------------
module zion_dat_read_pipe #(
   parameter int WIDTH_DATA_IN                = 32,
   parameter int WIDTH_DATA_OUT               = 32,
   parameter int NUM_TYPE                     = 2,
   parameter int MULTI_DATA_WIDTH [NUM_TYPE]  = '{16, 8},
   parameter int ADDR_TYPE                    = 0,
   parameter int WIDTH_ERRCNT                 = 8,
   localparam int WIDTH_ADDR                  = $clog2(WIDTH_DATA_IN / 8)
) (
   input  logic                      iClk,
   input  logic                      iRst_n,
   input  logic                      iClr,
   input  logic                      iVld,
   output logic                      oRdy,
   input  logic [NUM_TYPE-1:0]       iEn,
   input  logic [WIDTH_ADDR-1:0]     iAddr,
   input  logic                      iSigned,
   input  logic [WIDTH_DATA_IN-1:0]  iDat,
   output logic                      oVld,
   input  logic                      iRdy,
   output logic [WIDTH_DATA_OUT-1:0] oDat,
   output logic                      oErr,
   output logic [WIDTH_ERRCNT-1:0]   oErrCnt
);

   // Per-type candidate elements and lane/alignment errors
   logic [WIDTH_DATA_OUT-1:0] elem_w [NUM_TYPE];
   logic [NUM_TYPE-1:0]       lerr_w;
   // Per-type sign-extension fill, evaluated on the S1 register contents
   logic [WIDTH_DATA_OUT-1:0] sext_w [NUM_TYPE];

   // Stage 1 registers
   logic                      s1_vld_q;
   logic [WIDTH_DATA_OUT-1:0] s1_raw_q,  s1_raw_d;
   logic [NUM_TYPE-1:0]       s1_type_q, s1_type_d;
   logic                      s1_sgn_q;
   logic                      s1_err_q,  s1_err_d;
   logic                      s1_lerr;

   // Stage 2 / output registers
   logic                      s2_vld_q;
   logic [WIDTH_DATA_OUT-1:0] dat_q;
   logic                      err_q;
   logic [WIDTH_ERRCNT-1:0]   errcnt_q, errcnt_d;
   logic [WIDTH_DATA_OUT-1:0] s2_ext;

   logic                      s2_load;
   logic                      s1_free;
   logic                      deliver;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_TYPE; gi++) begin : g_type
         localparam int W     = MULTI_DATA_WIDTH[gi];
         localparam int NLANE = WIDTH_DATA_IN / W;
         localparam int BPE   = W / 8;
         localparam logic [WIDTH_DATA_IN-1:0]  IMASK = {WIDTH_DATA_IN{1'b1}} >> (WIDTH_DATA_IN - W);
         localparam logic [WIDTH_DATA_OUT-1:0] OMASK = {WIDTH_DATA_OUT{1'b1}} >> (WIDTH_DATA_OUT - W);

         int                       lane;
         logic                     lane_err;
         logic [WIDTH_DATA_IN-1:0] elem;

         always_comb begin
            lane     = 0;
            lane_err = 1'b0;
            // A full-width element has a single lane: the address is ignored.
            if (NLANE > 1) begin
               if (ADDR_TYPE == 1) begin
                  lane     = int'(iAddr) / BPE;
                  lane_err = (int'(iAddr) % BPE) != 0;
               end else begin
                  lane     = int'(iAddr);
               end
               if (lane >= NLANE) lane_err = 1'b1;
            end
            elem = (iDat >> (lane * W)) & IMASK;
         end

         assign elem_w[gi] = WIDTH_DATA_OUT'(elem);
         assign lerr_w[gi] = lane_err;

         // Fill the bits above W with ones when the stored element is negative.
         assign sext_w[gi] = (s1_type_q[gi] && s1_sgn_q && s1_raw_q[W-1]) ? ~OMASK : '0;
      end
   endgenerate

   // S1 next-state: select the candidate for the requested type and qualify it.
   always_comb begin
      s1_raw_d = '0;
      s1_lerr  = 1'b0;
      for (int t = 0; t < NUM_TYPE; t++) begin
         if (iEn[t]) begin
            s1_raw_d = s1_raw_d | elem_w[t];
            s1_lerr  = s1_lerr | lerr_w[t];
         end
      end
      s1_err_d = !$onehot(iEn) || s1_lerr;
      if (s1_err_d) s1_raw_d = '0;
      // A cleared type vector suppresses sign extension for error responses.
      s1_type_d = s1_err_d ? '0 : iEn;
   end

   // S2 extension
   always_comb begin
      s2_ext = s1_raw_q;
      for (int t = 0; t < NUM_TYPE; t++) begin
         s2_ext = s2_ext | sext_w[t];
      end
   end

   // Flow control: oRdy depends combinationally on iRdy through s2_load.
   assign deliver = s2_vld_q && iRdy;
   assign s2_load = !s2_vld_q || iRdy;
   assign s1_free = !s1_vld_q || s2_load;
   assign oRdy    = !iClr && s1_free;

   always_comb begin
      errcnt_d = errcnt_q;
      if (deliver && err_q && (errcnt_q != {WIDTH_ERRCNT{1'b1}})) begin
         errcnt_d = errcnt_q + WIDTH_ERRCNT'(1);
      end
   end

   always_ff @(posedge iClk or negedge iRst_n) begin
      if (!iRst_n) begin
         s1_vld_q  <= 1'b0;
         s1_raw_q  <= '0;
         s1_type_q <= '0;
         s1_sgn_q  <= 1'b0;
         s1_err_q  <= 1'b0;
         s2_vld_q  <= 1'b0;
         dat_q     <= '0;
         err_q     <= 1'b0;
         errcnt_q  <= '0;
      end else if (iClr) begin
         s1_vld_q  <= 1'b0;
         s2_vld_q  <= 1'b0;
         errcnt_q  <= '0;
      end else begin
         if (s2_load) begin
            s2_vld_q <= s1_vld_q;
            // Output data only changes when a real result moves in.
            if (s1_vld_q) begin
               dat_q <= s2_ext;
               err_q <= s1_err_q;
            end
         end
         if (s1_free) begin
            s1_vld_q <= iVld;
            if (iVld) begin
               s1_raw_q  <= s1_raw_d;
               s1_type_q <= s1_type_d;
               s1_sgn_q  <= iSigned;
               s1_err_q  <= s1_err_d;
            end
         end
         errcnt_q <= errcnt_d;
      end
   end

   assign oVld    = s2_vld_q;
   assign oDat    = dat_q;
   assign oErr    = err_q;
   assign oErrCnt = errcnt_q;

endmodule

// File: tb/tb_zion_dat_read_pipe.sv
// -----------------------------------------------------------------------------
// Bench for zion_dat_read_pipe with 32-bit words, byte addressing and element
// widths {16,8}. A second instance with a 2-bit error counter shares the
// stimulus so counter saturation can be observed alongside the main instance.
// -----------------------------------------------------------------------------
module tb_zion_dat_read_pipe;

   logic        iClk    = 1'b0;
   logic        iRst_n  = 1'b0;
   logic        iClr    = 1'b0;
   logic        iVld    = 1'b0;
   logic        iRdy    = 1'b0;
   logic        iSigned = 1'b0;
   logic [1:0]  iEn     = 2'b00;
   logic [1:0]  iAddr   = 2'd0;
   logic [31:0] iDat    = 32'h0;

   logic        oRdy,  oVld,  oErr;
   logic [31:0] oDat;
   logic [7:0]  oErrCnt;
   logic        oRdy2, oVld2, oErr2;
   logic [31:0] oDat2;
   logic [1:0]  oErrCnt2;

   zion_dat_read_pipe #(.ADDR_TYPE(1)) dut (
      .iClk(iClk), .iRst_n(iRst_n), .iClr(iClr), .iVld(iVld), .oRdy(oRdy),
      .iEn(iEn), .iAddr(iAddr), .iSigned(iSigned), .iDat(iDat),
      .oVld(oVld), .iRdy(iRdy), .oDat(oDat), .oErr(oErr), .oErrCnt(oErrCnt)
   );

   zion_dat_read_pipe #(.ADDR_TYPE(1), .WIDTH_ERRCNT(2)) dut_sat (
      .iClk(iClk), .iRst_n(iRst_n), .iClr(iClr), .iVld(iVld), .oRdy(oRdy2),
      .iEn(iEn), .iAddr(iAddr), .iSigned(iSigned), .iDat(iDat),
      .oVld(oVld2), .iRdy(iRdy), .oDat(oDat2), .oErr(oErr2), .oErrCnt(oErrCnt2)
   );

   always #5 iClk = ~iClk;

   typedef struct {
      logic [1:0]  en;
      logic [1:0]  addr;
      logic        sgn;
      logic [31:0] dat;
      logic [31:0] xdat;
      logic        xerr;
   } vec_t;

   typedef struct {
      logic [31:0] dat;
      logic        err;
      int          acc_cyc;
   } sb_t;

   vec_t        vecs [14];
   sb_t         sb_q [$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          exp_cnt8 = 0;
   int          exp_cnt2 = 0;
   logic [31:0] cur_dat  = 32'h0;
   logic        cur_err  = 1'b0;
   logic        stall_prev = 1'b0;
   logic [31:0] prev_dat = 32'h0;
   logic        prev_err = 1'b0;
   logic        last_acc = 1'b0;
   logic        chk_lat  = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Independent reference for the default configuration (32-bit word, byte
   // addressing, type 0 = 16-bit, type 1 = 8-bit).
   function automatic void model(input logic [1:0] en, input logic [1:0] addr,
                                 input logic sgn, input logic [31:0] dat,
                                 output logic [31:0] d, output logic e);
      logic [7:0]  b;
      logic [15:0] h;
      d = 32'h0;
      e = 1'b0;
      case (en)
         2'b10: begin
            b = dat[addr*8 +: 8];
            d = sgn ? {{24{b[7]}}, b} : {24'h0, b};
         end
         2'b01: begin
            if (addr[0]) e = 1'b1;
            else begin
               h = addr[1] ? dat[31:16] : dat[15:0];
               d = sgn ? {{16{h[15]}}, h} : {16'h0, h};
            end
         end
         default: e = 1'b1;
      endcase
   endfunction

   // Sample between edges, update the scoreboard, advance to the next negedge.
   task automatic tick();
      sb_t  e;
      logic acc, dlv, exp_rdy;
      #1;
      acc     = iVld && oRdy;
      dlv     = oVld && iRdy;
      exp_rdy = !iClr && ((sb_q.size() < 2) || iRdy);
      check("ready", 32'(oRdy), 32'(exp_rdy));
      check("errcnt", 32'(oErrCnt), 32'(exp_cnt8));
      check("errcnt_w2", 32'(oErrCnt2), 32'(exp_cnt2));
      if (stall_prev) begin
         check("stall_vld", 32'(oVld), 32'd1);
         check("stall_dat", oDat, prev_dat);
         check("stall_err", 32'(oErr), 32'(prev_err));
      end
      if (sb_q.size() == 0) check("idle_vld", 32'(oVld), 32'd0);
      if (dlv && sb_q.size() > 0) begin
         e = sb_q.pop_front();
         check("dat", oDat, e.dat);
         check("err", 32'(oErr), 32'(e.err));
         if (chk_lat) check("latency", 32'(cyc - e.acc_cyc), 32'd2);
         if (e.err) begin
            exp_cnt8 = (exp_cnt8 == 255) ? 255 : exp_cnt8 + 1;
            exp_cnt2 = (exp_cnt2 == 3) ? 3 : exp_cnt2 + 1;
         end
      end
      if (acc) sb_q.push_back('{cur_dat, cur_err, cyc});
      if (iClr) begin
         sb_q.delete();
         exp_cnt8 = 0;
         exp_cnt2 = 0;
      end
      stall_prev = oVld && !iRdy && !iClr;
      prev_dat   = oDat;
      prev_err   = oErr;
      last_acc   = acc;
      cyc++;
      @(negedge iClk);
   endtask

   task automatic drain();
      iVld = 1'b0;
      iRdy = 1'b1;
      for (int k = 0; k < 20 && sb_q.size() > 0; k++) tick();
      check("drain_empty", 32'(sb_q.size()), 32'd0);
   endtask

   task automatic send(input logic [1:0] en, input logic [1:0] addr,
                       input logic sgn, input logic [31:0] dat);
      iEn = en; iAddr = addr; iSigned = sgn; iDat = dat; iVld = 1'b1;
      model(en, addr, sgn, dat, cur_dat, cur_err);
   endtask

   initial begin
      vecs[0]  = '{2'b10, 2'd1, 1'b1, 32'hA5B6C7D8, 32'hFFFFFFC7, 1'b0};
      vecs[1]  = '{2'b01, 2'd2, 1'b0, 32'hA5B6C7D8, 32'h0000A5B6, 1'b0};
      vecs[2]  = '{2'b01, 2'd1, 1'b0, 32'hA5B6C7D8, 32'h00000000, 1'b1};
      vecs[3]  = '{2'b11, 2'd0, 1'b0, 32'hA5B6C7D8, 32'h00000000, 1'b1};
      vecs[4]  = '{2'b00, 2'd0, 1'b1, 32'hA5B6C7D8, 32'h00000000, 1'b1};
      vecs[5]  = '{2'b10, 2'd0, 1'b0, 32'hA5B6C7D8, 32'h000000D8, 1'b0};
      vecs[6]  = '{2'b10, 2'd3, 1'b1, 32'hA5B6C7D8, 32'hFFFFFFA5, 1'b0};
      vecs[7]  = '{2'b01, 2'd0, 1'b1, 32'hA5B6C7D8, 32'hFFFFC7D8, 1'b0};
      vecs[8]  = '{2'b01, 2'd2, 1'b1, 32'hA5B6C7D8, 32'hFFFFA5B6, 1'b0};
      vecs[9]  = '{2'b10, 2'd2, 1'b1, 32'hA5B6C7D8, 32'hFFFFFFB6, 1'b0};
      vecs[10] = '{2'b10, 2'd1, 1'b1, 32'h12347F80, 32'h0000007F, 1'b0};
      vecs[11] = '{2'b10, 2'd0, 1'b1, 32'h12347F80, 32'hFFFFFF80, 1'b0};
      vecs[12] = '{2'b01, 2'd3, 1'b1, 32'h12347F80, 32'h00000000, 1'b1};
      vecs[13] = '{2'b01, 2'd0, 1'b1, 32'h12347F80, 32'h00007F80, 1'b0};

      // Reset values while reset is held
      repeat (2) @(negedge iClk);
      check("rst_vld", 32'(oVld), 32'd0);
      check("rst_dat", oDat, 32'h0);
      check("rst_err", 32'(oErr), 32'd0);
      check("rst_cnt", 32'(oErrCnt), 32'd0);
      iRst_n = 1'b1;

      // Table vectors, back-to-back with iRdy held high
      chk_lat = 1'b1;
      iRdy    = 1'b1;
      for (int i = 0; i < 14; i++) begin
         iEn = vecs[i].en; iAddr = vecs[i].addr; iSigned = vecs[i].sgn;
         iDat = vecs[i].dat; iVld = 1'b1;
         cur_dat = vecs[i].xdat; cur_err = vecs[i].xerr;
         for (int t = 0; t < 8; t++) begin
            tick();
            if (last_acc) break;
         end
         if (!last_acc) check("accept_timeout", 32'd0, 32'd1);
      end
      drain();
      chk_lat = 1'b0;
      check("cnt_after_table", 32'(oErrCnt), 32'd4);
      check("cnt_w2_after_table", 32'(oErrCnt2), 32'd3);

      // Random stream with iRdy pattern 1,0,0,1
      for (int i = 0; i < 24; i++) begin
         case ($urandom_range(0, 5))
            0, 1:    send(2'b10, 2'($urandom), 1'($urandom), $urandom);
            2, 3:    send(2'b01, 2'($urandom), 1'($urandom), $urandom);
            4:       send(2'b11, 2'($urandom), 1'($urandom), $urandom);
            default: send(2'b00, 2'($urandom), 1'($urandom), $urandom);
         endcase
         iRdy = ((i % 4) == 0) || ((i % 4) == 3);
         tick();
      end
      drain();

      // Asynchronous reset with two requests in flight
      iRdy = 1'b0;
      send(2'b10, 2'd1, 1'b1, 32'hA5B6C7D8);
      tick();
      tick();
      #2;
      iRst_n = 1'b0;
      #1;
      check("arst_vld", 32'(oVld), 32'd0);
      check("arst_dat", oDat, 32'h0);
      check("arst_err", 32'(oErr), 32'd0);
      check("arst_cnt", 32'(oErrCnt), 32'd0);
      check("arst_cnt_w2", 32'(oErrCnt2), 32'd0);
      sb_q.delete();
      exp_cnt8 = 0; exp_cnt2 = 0; stall_prev = 1'b0;
      iVld = 1'b0;
      @(negedge iClk);
      iRst_n = 1'b1;
      iRdy   = 1'b1;
      repeat (4) tick();

      // Five errors: 8-bit counter reaches 5, 2-bit counter holds at 3
      for (int i = 0; i < 5; i++) begin
         send(2'b00, 2'd0, 1'b0, 32'h0);
         tick();
      end
      drain();
      check("sat_cnt8", 32'(oErrCnt), 32'd5);
      check("sat_cnt2", 32'(oErrCnt2), 32'd3);

      // Flush with both stages full
      iRdy = 1'b0;
      send(2'b01, 2'd2, 1'b0, 32'hCAFE1234);
      repeat (3) tick();
      iClr = 1'b1;
      tick();
      iClr = 1'b0;
      iVld = 1'b0;
      iRdy = 1'b1;
      check("clr_vld", 32'(oVld), 32'd0);
      check("clr_cnt", 32'(oErrCnt), 32'd0);
      repeat (4) tick();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

endmodule
